bus_ctrl: RTL and testbench

- Memory/IO bus controller between the processor's ADDR/DOUT/W outputs and its data input DIN.
- Decodes ADDR[15:12] into on-chip synchronous RAM, LED output register, switch input port, HEX output register and status register.
- Uses a req/ready handshake, so the processor can tolerate the one-cycle read latency of the synchronous RAM.
- Replaces the current combinational chip-select and standalone LED register.

---
 rtl/bus_ctrl_if.sv | 27 ++
 rtl/bus_ctrl.sv | 147 ++++++++++++++
 tb/tb_bus_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/bus_ctrl_if.sv
// ----------------------------------------------------------------------------
// bus_ctrl_if
//   Processor-side request/response bus of the memory/IO controller.
//
//   Signals:
//     req    processor request, held high until ready
//     we     1 = write, 0 = read; valid with req
//     ADDR   16-bit word address, ADDR[15:12] selects the region
//     DOUT   write data from the processor
//     rdata  read data returned to the processor (its DIN)
//     ready  one-cycle completion pulse
//
//   Modports:
//     master  processor side (drives req/we/ADDR/DOUT)
//     slave   controller side (drives rdata/ready)
// ----------------------------------------------------------------------------
interface bus_ctrl_if;
   logic        req;
   logic        we;
   logic [15:0] ADDR;
   logic [15:0] DOUT;
   logic [15:0] rdata;
   logic        ready;

   modport master (output req, we, ADDR, DOUT, input  rdata, ready);
   modport slave  (input  req, we, ADDR, DOUT, output rdata, ready);
endinterface

// File: rtl/bus_ctrl.sv
// ----------------------------------------------------------------------------
// bus_ctrl
//   Memory/IO bus controller. Decodes ADDR[15:12] into on-chip synchronous
//   RAM, LED register, switch input port, HEX register and status register,
//   and completes every access with a one-cycle ready pulse so the processor
//   can tolerate the RAM's one-cycle read latency.
//
//   Ports:
//     Clock     system clock, all state on the rising edge
//     Resetn    synchronous active-low reset
//     bus       processor bus (req/we/ADDR/DOUT in, rdata/ready out)
//     mem_addr  RAM word address, ADDR[MEM_AW-1:0] (combinational)
//     mem_data  RAM write data, DOUT (combinational)
//     mem_wren  RAM write enable, only in the accept cycle of a RAM write
//     mem_q     RAM read data, valid one cycle after the address
//     sw_in     asynchronous switch inputs
//     led_out   LED register
//     hex_out   HEX display register
//     err       sticky bad-address flag, cleared by reading STATUS
// ----------------------------------------------------------------------------
module bus_ctrl #(
   parameter int MEM_AW = 8,
   parameter int SW_W   = 16
) (
   input  logic              Clock,
   input  logic              Resetn,
   bus_ctrl_if.slave         bus,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [15:0]       mem_data,
   output logic              mem_wren,
   input  logic [15:0]       mem_q,
   input  logic [SW_W-1:0]   sw_in,
   output logic [15:0]       led_out,
   output logic [15:0]       hex_out,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

   localparam logic [3:0] REG_RAM    = 4'h0;
   localparam logic [3:0] REG_LED    = 4'h1;
   localparam logic [3:0] REG_SW     = 4'h2;
   localparam logic [3:0] REG_HEX    = 4'h3;
   localparam logic [3:0] REG_STATUS = 4'h4;

   state_t            state_q, state_d;
   logic [15:0]       rdata_q, rdata_d;
   logic [15:0]       led_q,   led_d;
   logic [15:0]       hex_q,   hex_d;
   logic              err_q,   err_d;
   logic [SW_W-1:0]   sw_meta_q, sw_sync_q;
   logic [15:0]       sw_ext;
   logic [3:0]        region;
   logic              unused_addr_bits;

   assign region = bus.ADDR[15:12];

   // The RAM region aliases, so the upper in-region address bits are unused.
   assign unused_addr_bits = ^bus.ADDR[11:MEM_AW];

   always_comb begin
      sw_ext              = '0;
      sw_ext[SW_W-1:0]    = sw_sync_q;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others; the reset here is synchronous.
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state_q   <= IDLE;
         rdata_q   <= '0;
         led_q     <= '0;
         hex_q     <= '0;
         err_q     <= 1'b0;
         sw_meta_q <= '0;
         sw_sync_q <= '0;
      end else begin
         state_q   <= state_d;
         rdata_q   <= rdata_d;
         led_q     <= led_d;
         hex_q     <= hex_d;
         err_q     <= err_d;
         sw_meta_q <= sw_in;
         sw_sync_q <= sw_meta_q;
      end
   end

   always_comb begin
      // NOTE: every next-state value gets its hold default first, so no path
      // through the case statement can leave one unassigned (no latches).
      state_d = state_q;
      rdata_d = rdata_q;
      led_d   = led_q;
      hex_d   = hex_q;
      err_d   = err_q;

      unique case (state_q)
         IDLE: begin
            if (bus.req) begin
               state_d = RESP;
               if (bus.we) begin
                  // RAM writes happen through mem_wren; SW/STATUS ignore writes.
                  case (region)
                     REG_RAM, REG_SW, REG_STATUS: ;
                     REG_LED: led_d = bus.DOUT;
                     REG_HEX: hex_d = bus.DOUT;
                     default: err_d = 1'b1;
                  endcase
               end else begin
                  case (region)
                     REG_RAM:    state_d = RD_WAIT;
                     REG_LED:    rdata_d = led_q;
                     REG_SW:     rdata_d = sw_ext;
                     REG_HEX:    rdata_d = hex_q;
                     REG_STATUS: begin
                        rdata_d = {15'b0, err_q};
                        err_d   = 1'b0;
                     end
                     default: begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                     end
                  endcase
               end
            end
         end
         RD_WAIT: begin
            rdata_d = mem_q;
            state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign mem_addr  = bus.ADDR[MEM_AW-1:0];
   assign mem_data  = bus.DOUT;
   // Gated by Resetn so a reset cycle can never write the RAM.
   assign mem_wren  = Resetn & bus.req & bus.we & (state_q == IDLE) & (region == REG_RAM);

   assign bus.ready = Resetn & (state_q == RESP);
   assign bus.rdata = rdata_q;
   assign led_out   = led_q;
   assign hex_out   = hex_q;
   assign err       = err_q;

endmodule

// File: tb/tb_bus_ctrl.sv
// ----------------------------------------------------------------------------
// tb_bus_ctrl
//   Self-checking bench for bus_ctrl. A behavioural synchronous RAM sits on
//   the mem_* port; a transaction-level reference model (arrays and plain
//   variables) predicts rdata, latency and register contents.
// ----------------------------------------------------------------------------
module tb_bus_ctrl;

   localparam int MEM_AW = 8;
   localparam int SW_W   = 16;

   logic              clk;
   logic              rst_n;
   logic [MEM_AW-1:0] mem_addr;
   logic [15:0]       mem_data;
   logic              mem_wren;
   logic [15:0]       mem_q;
   logic [SW_W-1:0]   sw_in;
   logic [15:0]       led_out;
   logic [15:0]       hex_out;
   logic              err;

   bus_ctrl_if bus ();

   bus_ctrl #(.MEM_AW(MEM_AW), .SW_W(SW_W)) dut (
      .Clock    (clk),
      .Resetn   (rst_n),
      .bus      (bus),
      .mem_addr (mem_addr),
      .mem_data (mem_data),
      .mem_wren (mem_wren),
      .mem_q    (mem_q),
      .sw_in    (sw_in),
      .led_out  (led_out),
      .hex_out  (hex_out),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAM attached to the controller (not reset).
   logic [15:0] tb_ram [2**MEM_AW];
   initial for (int i = 0; i < 2**MEM_AW; i++) tb_ram[i] = '0;
   always @(posedge clk) begin
      if (mem_wren) tb_ram[mem_addr] <= mem_data;
      mem_q <= tb_ram[mem_addr];
   end

   // Reference model state.
   logic [15:0] ref_ram [2**MEM_AW];
   logic [15:0] ref_led, ref_hex, ref_rdata, ref_sw;
   logic        ref_err;

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Applies one access to the model; returns expected rdata and latency.
   task automatic model_txn(input logic w, input logic [15:0] a, input logic [15:0] d,
                            output logic [15:0] exp_rd, output int exp_lat);
      int r;
      r       = int'(a[15:12]);
      exp_lat = 1;
      if (w) begin
         if (r == 0)      ref_ram[a[MEM_AW-1:0]] = d;
         else if (r == 1) ref_led = d;
         else if (r == 3) ref_hex = d;
         else if (r >= 5) ref_err = 1'b1;
      end else begin
         if (r == 0) begin
            ref_rdata = ref_ram[a[MEM_AW-1:0]];
            exp_lat   = 2;
         end
         else if (r == 1) ref_rdata = ref_led;
         else if (r == 2) ref_rdata = ref_sw;
         else if (r == 3) ref_rdata = ref_hex;
         else if (r == 4) begin
            ref_rdata = {15'b0, ref_err};
            ref_err   = 1'b0;
         end else begin
            ref_rdata = '0;
            ref_err   = 1'b1;
         end
      end
      exp_rd = ref_rdata;
   endtask

   task automatic run_txn(input logic w, input logic [15:0] a, input logic [15:0] d);
      logic [15:0] exp_rd;
      int          exp_lat;
      int          lat;
      model_txn(w, a, d, exp_rd, exp_lat);
      @(negedge clk);
      bus.req  = 1'b1;
      bus.we   = w;
      bus.ADDR = a;
      bus.DOUT = d;
      #1;
      check("mem_wren_accept", mem_wren, w && (a[15:12] == 4'h0));
      check("mem_addr", mem_addr, a[MEM_AW-1:0]);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.ready && lat < 8);
      check("latency", lat, exp_lat);
      check("rdata", bus.rdata, exp_rd);
      check("led_out", led_out, ref_led);
      check("hex_out", hex_out, ref_hex);
      check("err", err, ref_err);
      check("mem_wren_resp", mem_wren, 1'b0);
      bus.req = 1'b0;
   endtask

   task automatic settle_sw(input logic [SW_W-1:0] v);
      sw_in  = v;
      ref_sw = 16'(v);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      logic [15:0] a;
      int          rcnt;
      for (int i = 0; i < 2**MEM_AW; i++) ref_ram[i] = '0;
      ref_led = '0; ref_hex = '0; ref_rdata = '0; ref_err = 1'b0; ref_sw = '0;

      // Reset held for two cycles with a RAM write request pending.
      rst_n    = 1'b0;
      sw_in    = '0;
      bus.req  = 1'b1;
      bus.we   = 1'b1;
      bus.ADDR = 16'h0005;
      bus.DOUT = 16'hDEAD;
      repeat (2) begin
         @(negedge clk);
         check("rst_mem_wren", mem_wren, 1'b0);
         check("rst_ready", bus.ready, 1'b0);
         check("rst_led", led_out, 16'h0);
         check("rst_hex", hex_out, 16'h0);
         check("rst_err", err, 1'b0);
         check("rst_rdata", bus.rdata, 16'h0);
      end
      bus.req = 1'b0;
      rst_n   = 1'b1;
      @(negedge clk);
      check("rst_no_ram_write", tb_ram[5], 16'h0);

      // LED, HEX and readback.
      run_txn(1'b1, 16'h1000, 16'hBEEF);
      run_txn(1'b1, 16'h3000, 16'h1234);
      run_txn(1'b0, 16'h1000, 16'h0000);

      // RAM write, read, alias read.
      run_txn(1'b1, 16'h0003, 16'hA5A5);
      run_txn(1'b0, 16'h0003, 16'h0000);
      run_txn(1'b0, 16'h0103, 16'h0000);

      // Switches.
      settle_sw(16'h00F0);
      run_txn(1'b0, 16'h2000, 16'h0000);
      run_txn(1'b1, 16'h2000, 16'hFFFF);

      // Unmapped write, STATUS read twice.
      run_txn(1'b1, 16'h7000, 16'h5555);
      run_txn(1'b0, 16'h4000, 16'h0000);
      run_txn(1'b0, 16'h4000, 16'h0000);

      // Back-to-back: req held across RESP gives two writes, ready 2 cycles apart.
      @(negedge clk);
      bus.req  = 1'b1;
      bus.we   = 1'b1;
      bus.ADDR = 16'h1000;
      bus.DOUT = 16'h1111;
      rcnt = 0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         check("b2b_ready", bus.ready, (c == 1 || c == 3));
         if (c == 1) begin
            check("b2b_led1", led_out, 16'h1111);
            bus.DOUT = 16'h2222;
         end
         if (c == 3) begin
            check("b2b_led2", led_out, 16'h2222);
            bus.req = 1'b0;
         end
      end
      ref_led = 16'h2222;

      // Abort: reset during RD_WAIT of a RAM read.
      @(negedge clk);
      bus.req  = 1'b1;
      bus.we   = 1'b0;
      bus.ADDR = 16'h0003;
      @(negedge clk);
      check("abort_in_rdwait", bus.ready, 1'b0);
      rst_n   = 1'b0;
      bus.req = 1'b0;
      @(negedge clk);
      check("abort_ready", bus.ready, 1'b0);
      check("abort_rdata", bus.rdata, 16'h0);
      rst_n = 1'b1;
      ref_led = '0; ref_hex = '0; ref_err = 1'b0; ref_rdata = '0;
      repeat (2) begin
         @(negedge clk);
         check("abort_no_ready", bus.ready, 1'b0);
      end
      settle_sw(16'h00F0);
      run_txn(1'b0, 16'h0003, 16'h0000);

      // Randomized traffic against the reference model.
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 15) == 0) begin
            settle_sw(SW_W'($urandom));
         end else begin
            a = 16'($urandom);
            a[15:12] = 4'($urandom_range(0, 7));
            if (a[15:12] == 4'h0) a[7:0] = 8'($urandom_range(0, 7));
            run_txn(1'($urandom_range(0, 1)), a, 16'($urandom));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
